mem_arbiter: RTL

Two-requester memory arbiter between the instruction cache, the data cache and the single shared memory port. It merges ICache refill requests (read-only) and DCache refill/writeback requests onto one request channel. It tags each request with its source and steers memory responses and nacks back to the originating cache through a registered response stage. DCache writeback bursts are atomic on the memory port: once the first beat is granted, no ICache request is interleaved until the last beat is accepted.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the cache/memory arbiter: memory geometry, tag widths
// and source encodings.
package mem_arbiter_pkg;

  localparam int CPU_DATA_BITS   = 64;
  localparam int MEM_DATA_BITS   = 128;
  localparam int MEM_DATA_CYCLES = 4;
  localparam int IC_MEM_TAG_BITS = 3;
  localparam int DC_MEM_TAG_BITS = 4;

  localparam logic SRC_DC = 1'b0;
  localparam logic SRC_IC = 1'b1;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A counter needs at least one bit even for single-beat lines.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? ceil_log2(n) : 1;
  endfunction

  localparam int MEM_LSB = ceil_log2(MEM_DATA_BITS / CPU_DATA_BITS);

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates ICache and DCache onto one memory request port, keeps DCache
// writeback bursts atomic, and steers registered responses back by source.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 29,
  parameter int DATA_CYCLES    = MEM_DATA_CYCLES,
  parameter int IC_TAG_BITS    = IC_MEM_TAG_BITS,
  parameter int DC_TAG_BITS    = DC_MEM_TAG_BITS
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            ic_req_val,
  output logic                                            ic_req_rdy,
  input  logic [WORD_ADDR_BITS-MEM_LSB-1:0]               ic_req_addr,
  input  logic [IC_TAG_BITS-1:0]                          ic_req_tag,
  output logic                                            ic_resp_val,
  output logic                                            ic_resp_nack,
  output logic [MEM_DATA_BITS-1:0]                        ic_resp_data,
  output logic [IC_TAG_BITS-1:0]                          ic_resp_tag,
  input  logic                                            dc_req_val,
  output logic                                            dc_req_rdy,
  input  logic                                            dc_req_rw,
  input  logic [WORD_ADDR_BITS-MEM_LSB-1:0]               dc_req_addr,
  input  logic [MEM_DATA_BITS-1:0]                        dc_req_data,
  input  logic [DC_TAG_BITS-1:0]                          dc_req_tag,
  output logic                                            dc_resp_val,
  output logic                                            dc_resp_nack,
  output logic [MEM_DATA_BITS-1:0]                        dc_resp_data,
  output logic [DC_TAG_BITS-1:0]                          dc_resp_tag,
  output logic                                            mem_req_val,
  input  logic                                            mem_req_rdy,
  output logic                                            mem_req_rw,
  output logic [WORD_ADDR_BITS-MEM_LSB-1:0]               mem_req_addr,
  output logic [MEM_DATA_BITS-1:0]                        mem_req_data,
  output logic [max_int(IC_TAG_BITS, DC_TAG_BITS):0]      mem_req_tag,
  input  logic                                            mem_resp_val,
  input  logic                                            mem_resp_nack,
  input  logic [MEM_DATA_BITS-1:0]                        mem_resp_data,
  input  logic [max_int(IC_TAG_BITS, DC_TAG_BITS):0]      mem_resp_tag
);

  localparam int TB = max_int(IC_TAG_BITS, DC_TAG_BITS);
  localparam int CW = cnt_bits(DATA_CYCLES);

  logic                     lock;
  logic [CW-1:0]            beat_cnt;
  logic                     prio;
  logic                     r_val;
  logic                     r_nack;
  logic                     r_src;
  logic [MEM_DATA_BITS-1:0] r_data;
  logic [TB-1:0]            r_tag;

  logic                     grant_ic;
  logic [TB-1:0]            ic_tag_ext;
  logic [TB-1:0]            dc_tag_ext;
  logic                     req_fire;
  logic                     dc_wr_fire;
  logic                     last_beat;

  // Grant selection: an open writeback burst pins the grant to the DCache.
  always_comb begin
    grant_ic = 1'b0;
    if (lock) begin
      grant_ic = 1'b0;
    end else if (ic_req_val && dc_req_val) begin
      grant_ic = prio;
    end else if (ic_req_val) begin
      grant_ic = 1'b1;
    end else begin
      grant_ic = 1'b0;
    end
  end

  // Request mux toward memory and ready fan-back to the caches.
  always_comb begin
    ic_tag_ext                   = {TB{1'b0}};
    dc_tag_ext                   = {TB{1'b0}};
    ic_tag_ext[IC_TAG_BITS-1:0]  = ic_req_tag;
    dc_tag_ext[DC_TAG_BITS-1:0]  = dc_req_tag;
    mem_req_data                 = dc_req_data;
    if (grant_ic) begin
      mem_req_val  = ic_req_val;
      mem_req_rw   = 1'b0;
      mem_req_addr = ic_req_addr;
      mem_req_tag  = {SRC_IC, ic_tag_ext};
      ic_req_rdy   = mem_req_rdy;
      dc_req_rdy   = 1'b0;
    end else begin
      mem_req_val  = dc_req_val;
      mem_req_rw   = dc_req_rw;
      mem_req_addr = dc_req_addr;
      mem_req_tag  = {SRC_DC, dc_tag_ext};
      ic_req_rdy   = 1'b0;
      dc_req_rdy   = mem_req_rdy;
    end
  end

  assign req_fire   = mem_req_val & mem_req_rdy;
  assign dc_wr_fire = req_fire & ~grant_ic & dc_req_rw;
  assign last_beat  = (beat_cnt == CW'(DATA_CYCLES - 1));

  // Burst lock, beat counter and round-robin priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock     <= 1'b0;
      beat_cnt <= {CW{1'b0}};
      prio     <= 1'b0;
    end else if (dc_wr_fire) begin
      if (last_beat) begin
        lock     <= 1'b0;
        beat_cnt <= {CW{1'b0}};
        prio     <= 1'b1;
      end else begin
        lock     <= 1'b1;
        beat_cnt <= beat_cnt + CW'(1);
        prio     <= prio;
      end
    end else if (req_fire) begin
      // Favour whichever source was not just served.
      prio     <= ~grant_ic;
      lock     <= lock;
      beat_cnt <= beat_cnt;
    end else begin
      lock     <= lock;
      beat_cnt <= beat_cnt;
      prio     <= prio;
    end
  end

  // One-cycle response stage; data and tag hold between beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_val  <= 1'b0;
      r_nack <= 1'b0;
      r_src  <= SRC_DC;
      r_data <= {MEM_DATA_BITS{1'b0}};
      r_tag  <= {TB{1'b0}};
    end else if (mem_resp_val || mem_resp_nack) begin
      r_val  <= mem_resp_val;
      r_nack <= mem_resp_nack;
      r_src  <= mem_resp_tag[TB];
      r_data <= mem_resp_data;
      r_tag  <= mem_resp_tag[TB-1:0];
    end else begin
      r_val  <= 1'b0;
      r_nack <= 1'b0;
      r_src  <= r_src;
      r_data <= r_data;
      r_tag  <= r_tag;
    end
  end

  assign ic_resp_val  = r_val  & (r_src == SRC_IC);
  assign ic_resp_nack = r_nack & (r_src == SRC_IC);
  assign dc_resp_val  = r_val  & (r_src == SRC_DC);
  assign dc_resp_nack = r_nack & (r_src == SRC_DC);
  assign ic_resp_data = r_data;
  assign dc_resp_data = r_data;
  assign ic_resp_tag  = r_tag[IC_TAG_BITS-1:0];
  assign dc_resp_tag  = r_tag[DC_TAG_BITS-1:0];

endmodule
